conv_kern_par: RTL and testbench
================================

CONV_KERN_PAR -- requirements
Module: conv_kern_par

Interface
REQ-001 Parameter WI, default 8: signed width of each weight and data element.
REQ-002 Parameter LANES, default 16: number of weight/data element pairs per input beat.
REQ-003 Parameter ACC_BITS, default 32: signed accumulator width.
REQ-004 Parameter PARAM_BITS, default 16: signed width of scale and bias.
REQ-005 Parameter ACT_BITS, default 8: output activation width.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two and at least 2: output FIFO entries.
REQ-007 Ports, in order:
- clk, input, 1: the single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: beat valid.
- in_ready, output, 1: beat can be accepted.
- win, input, LANES*WI: packed signed weights; lane i is at [i*WI +: WI].
- din, input, LANES*WI: packed signed data, same layout.
- cfg_beats, input, 8: beats per output group; 0 means 256.
- is_last_layer, input, 1: 1 selects a signed clamp with no ReLU.
- scale, input, PARAM_BITS: signed multiplier.
- bias, input, PARAM_BITS: signed, sign-extended before it is added.
- scale_shift, input, 6: arithmetic right-shift amount.
- out_valid, output, 1: FIFO head is valid.
- out_ready, input, 1: consumer accepts the FIFO head.
- out_data, output, ACT_BITS: activation.
- busy, output, 1: a group is open, a result is in flight, or the FIFO is non-empty.

Function
REQ-008 A beat is accepted on a clock edge where in_valid=1 and in_ready=1; nothing else advances a group.
REQ-009 cfg_beats, is_last_layer, scale, bias and scale_shift are sampled on the first accepted beat of a group and held until that group's result is written; changes mid-group are ignored.
REQ-010 Group FSM, 2 states:
- IDLE to ACC on the first accepted beat when cfg_beats is not 1.
- ACC to IDLE on acceptance of beat number cfg_beats.
- With cfg_beats=1 the FSM stays in IDLE and every beat is its own complete group.
REQ-011 Pipeline, which never stalls, with the accepting edge at cycle T:
- S1 at T+1: registers the signed sum of the LANES products.
- S2 at T+2: accumulates. The first beat of a group loads the sum; later beats add to it, wrapping in two's complement at ACC_BITS.
- S3 at T+3, last beat only: registers (acc + bias) * scale at full width ACC_BITS+PARAM_BITS+1.
- S4 at T+4 edge: shift, activate, saturate, then write the FIFO.
REQ-012 Activation when is_last_layer=0: negative values become 0, and the result saturates to [0, 2^ACT_BITS-1].
REQ-013 Activation when is_last_layer=1: signed saturation to [-2^(ACT_BITS-1), 2^(ACT_BITS-1)-1].
REQ-014 With the FIFO empty, out_valid=1 and out_data hold the result in the cycle after the T+4 edge, so end-to-end latency is 5 cycles from acceptance of the last beat.
REQ-015 Credit rule: in_ready = ((FIFO count + results in S1..S4 that close a group) < FIFO_DEPTH).
- in_ready depends only on registered state, never combinationally on in_valid or out_ready.
REQ-016 FIFO behaviour:
- It pops on out_valid and out_ready.
- A simultaneous push and pop leaves the count unchanged.
- The FIFO never overflows under the credit rule.
- out_data is stable while out_valid=1 and out_ready=0.
REQ-017 Groups follow each other back to back: the first beat of group k+1 may be accepted in the cycle after the last beat of group k, and each group uses its own sampled configuration.
REQ-018 A scale_shift of ACC_BITS+PARAM_BITS or more yields 0 for a non-negative value and -1 for a negative value before activation.

Reset
REQ-019 rst=1 on a clock edge forces the following state:
- FSM to IDLE, beat counter to 0, all pipeline valid flags to 0.
- FIFO empty, out_valid=0, out_data=0, busy=0, and in_ready=1 from the next cycle.
REQ-020 A reset during an open group or with results in flight discards that work; no partial result is ever output.

Configuration
REQ-021 Macro CONV_KERN_PAR_ROUND_EN.
- When defined, S4 adds 2^(scale_shift-1) before shifting when scale_shift>0 (round half up).
- When undefined, S4 truncates toward negative infinity.
- All latencies and handshakes are the same in both builds.

Verification
REQ-022 cfg_beats=1, all win=1, all din=2, bias=0, scale=1, shift=0, last=0 -> out_data=32 (2*16), 5 cycles after acceptance.
REQ-023 cfg_beats=3, each beat sums to -10, bias=5, scale=2, shift=1, last=0 -> out_data=0; the same stimulus with last=1 -> out_data=-25.
REQ-024 out_ready=0 with 10 single-beat groups offered back to back -> exactly FIFO_DEPTH accepted, then in_ready=0; release out_ready -> all results out in order, none lost.
REQ-025 Sum 300 with scale=1, shift=0, last=0 -> 255; sum -300 with last=1 -> -128.
REQ-026 rst=1 mid-group after 2 of 4 beats -> no output; the next 4-beat group produces only its own result.
REQ-027 Sum 3, shift=1 -> 2 with CONV_KERN_PAR_ROUND_EN defined and 1 without it.

Source files
------------

// File: rtl/conv_kern_par.sv
// conv_kern_par: parallel multiply-accumulate kernel with scale/bias,
// ReLU or signed-clamp activation and a credit-protected output FIFO.
// Optional build macro CONV_KERN_PAR_ROUND_EN: round half up in the final
// shift instead of truncating toward negative infinity.
//
// state | meaning
// IDLE  | no group open; next accepted beat starts a group
// ACC   | group open; waiting for the remaining beats of the group
module conv_kern_par #(
  parameter int WI         = 8,
  parameter int LANES      = 16,
  parameter int ACC_BITS   = 32,
  parameter int PARAM_BITS = 16,
  parameter int ACT_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WI-1:0]    win,
  input  logic [LANES*WI-1:0]    din,
  input  logic [7:0]             cfg_beats,
  input  logic                   is_last_layer,
  input  logic [PARAM_BITS-1:0]  scale,
  input  logic [PARAM_BITS-1:0]  bias,
  input  logic [5:0]             scale_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACT_BITS-1:0]    out_data,
  output logic                   busy
);
  localparam int P  = ACC_BITS + PARAM_BITS + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic signed [P:0] S_MAX   = (P+1)'(2**(ACT_BITS-1) - 1);
  localparam logic signed [P:0] S_MIN   = (P+1)'(-(2**(ACT_BITS-1)));
  localparam logic signed [P:0] U_MAX   = (P+1)'(2**ACT_BITS - 1);
  localparam logic signed [P:0] RND_ONE = {{P{1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;

  logic       accept, first_beat, last_beat;
  logic [7:0] rem;
  logic                         h_ll;
  logic signed [PARAM_BITS-1:0] h_scale, h_bias;
  logic [5:0]                   h_shift;

  // Stage registers: s0 input capture, s1 lane sum, s2 accumulator, s3 product
  logic                         s0_valid, s0_first, s0_last, s0_ll;
  logic [LANES*WI-1:0]          s0_win, s0_din;
  logic signed [PARAM_BITS-1:0] s0_scale, s0_bias;
  logic [5:0]                   s0_shift;
  logic                         s1_valid, s1_first, s1_last, s1_ll;
  logic signed [ACC_BITS-1:0]   s1_sum;
  logic signed [PARAM_BITS-1:0] s1_scale, s1_bias;
  logic [5:0]                   s1_shift;
  logic                         s2_valid, s2_last, s2_ll;
  logic signed [ACC_BITS-1:0]   acc;
  logic signed [PARAM_BITS-1:0] s2_scale, s2_bias;
  logic [5:0]                   s2_shift;
  logic                         s3_valid, s3_ll;
  logic signed [P-1:0]          s3_prod;
  logic [5:0]                   s3_shift;

  logic signed [ACC_BITS-1:0]   lane_sum;
  logic signed [WI-1:0]         lw, ld;
  logic signed [2*WI-1:0]       lp;
  logic signed [ACC_BITS:0]     acc_b;
  logic signed [P:0]            pre, shd;
  logic [ACT_BITS-1:0]          act;

  logic [ACT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [CW-1:0]       count;
  logic [CW+1:0]       credits;
  logic                push, pop;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cfg_beats != 8'd1) state_nxt = ACC;
      ACC:     if (accept && rem == 8'd1)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: beat position within the group
  always_comb begin
    accept     = in_valid && in_ready;
    first_beat = (state == IDLE);
    last_beat  = (state == IDLE) ? (cfg_beats == 8'd1) : (rem == 8'd1);
  end

  // Remaining-beat down-counter and per-group configuration hold
  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      h_ll    <= 1'b0;
      h_scale <= '0;
      h_bias  <= '0;
      h_shift <= '0;
    end else if (accept) begin
      if (first_beat) begin
        rem     <= cfg_beats - 8'd1;   // 0 wraps to 255, i.e. 256 beats
        h_ll    <= is_last_layer;
        h_scale <= scale;
        h_bias  <= bias;
        h_shift <= scale_shift;
      end else begin
        rem <= rem - 8'd1;
      end
    end
  end

  // Pipeline valid flags; configuration rides along so back-to-back groups keep their own
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid && s2_last;
    end
  end

  // Lane dot product of the captured beat
  always_comb begin
    lane_sum = '0;
    lw = '0;
    ld = '0;
    lp = '0;
    for (int i = 0; i < LANES; i++) begin
      lw = s0_win[i*WI +: WI];
      ld = s0_din[i*WI +: WI];
      lp = lw * ld;
      lane_sum = lane_sum + ACC_BITS'(lp);
    end
  end

  // Sign-extended bias added at full accumulator width plus one
  always_comb begin
    acc_b = {acc[ACC_BITS-1], acc}
          + {{(ACC_BITS+1-PARAM_BITS){s2_bias[PARAM_BITS-1]}}, s2_bias};
  end

  // Datapath registers (no reset needed; qualified by the valid flags)
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_win   <= win;
      s0_din   <= din;
      s0_first <= first_beat;
      s0_last  <= last_beat;
      s0_ll    <= first_beat ? is_last_layer : h_ll;
      s0_scale <= first_beat ? scale         : h_scale;
      s0_bias  <= first_beat ? bias          : h_bias;
      s0_shift <= first_beat ? scale_shift   : h_shift;
    end
    s1_sum   <= lane_sum;
    s1_first <= s0_first;
    s1_last  <= s0_last;
    s1_ll    <= s0_ll;
    s1_scale <= s0_scale;
    s1_bias  <= s0_bias;
    s1_shift <= s0_shift;
    if (s1_valid) acc <= s1_first ? s1_sum : acc + s1_sum;
    s2_last  <= s1_last;
    s2_ll    <= s1_ll;
    s2_scale <= s1_scale;
    s2_bias  <= s1_bias;
    s2_shift <= s1_shift;
    s3_prod  <= P'(acc_b) * P'(s2_scale);
    s3_ll    <= s2_ll;
    s3_shift <= s2_shift;
  end

  // Shift, activate and saturate the product on its way into the FIFO
  always_comb begin
    pre = {s3_prod[P-1], s3_prod};
`ifdef CONV_KERN_PAR_ROUND_EN
    if (s3_shift != 6'd0) pre = pre + (RND_ONE << (s3_shift - 6'd1));
`endif
    if (int'(s3_shift) >= P - 1) shd = {(P+1){s3_prod[P-1]}};
    else                         shd = pre >>> s3_shift;
    if (s3_ll) begin
      if (shd > S_MAX)      act = S_MAX[ACT_BITS-1:0];
      else if (shd < S_MIN) act = S_MIN[ACT_BITS-1:0];
      else                  act = shd[ACT_BITS-1:0];
    end else begin
      if (shd[P])           act = '0;
      else if (shd > U_MAX) act = '1;
      else                  act = shd[ACT_BITS-1:0];
    end
  end

  // Credits: every group-closing beat still in the pipe reserves a FIFO slot
  always_comb begin
    credits  = (CW+2)'(count)
             + (CW+2)'(s0_valid && s0_last)
             + (CW+2)'(s1_valid && s1_last)
             + (CW+2)'(s2_valid && s2_last)
             + (CW+2)'(s3_valid);
    in_ready  = (credits < (CW+2)'(FIFO_DEPTH));
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rp] : '0;
    push      = s3_valid;
    pop       = out_valid && out_ready;
    busy      = (state == ACC) || s0_valid || s1_valid || s2_valid || s3_valid || out_valid;
  end

  // Output FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= act;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_conv_kern_par.sv
// Scoreboard bench for conv_kern_par: stimulus pushes expected activations,
// a negedge monitor pops and compares each output handshake.
module tb_conv_kern_par;
  localparam int WI = 8, LANES = 16, ACC_BITS = 32, PARAM_BITS = 16;
  localparam int ACT_BITS = 8, FIFO_DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready;
  logic [LANES*WI-1:0] win = '0, din = '0;
  logic [7:0] cfg_beats = 8'd1;
  logic is_last_layer = 1'b0;
  logic [PARAM_BITS-1:0] scale = 16'd1, bias = '0;
  logic [5:0] scale_shift = '0;
  logic out_valid, out_ready = 1'b1, busy;
  logic [ACT_BITS-1:0] out_data;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int lat, acc_n, hold_v;

  always #5 clk = ~clk;

  conv_kern_par #(.WI(WI), .LANES(LANES), .ACC_BITS(ACC_BITS), .PARAM_BITS(PARAM_BITS),
                  .ACT_BITS(ACT_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .win(win), .din(din), .cfg_beats(cfg_beats), .is_last_layer(is_last_layer),
    .scale(scale), .bias(bias), .scale_shift(scale_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %0d expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e) begin
          errors++;
          $display("FAIL out_data got %0d expected %0d", out_data, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic set_lane0(input int w, input int d);
    logic [7:0] wb, db;
    wb = w[7:0];
    db = d[7:0];
    win = '0;
    din = '0;
    win[7:0] = wb;
    din[7:0] = db;
  endtask

  task automatic set_cfg(input int beats, input int ll, input int sc, input int bi, input int sh);
    cfg_beats     = beats[7:0];
    is_last_layer = ll[0];
    scale         = sc[15:0];
    bias          = bi[15:0];
    scale_shift   = sh[5:0];
  endtask

  task automatic do_beat();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // One group of 'beats' identical lane-0 beats
  task automatic group(input int beats, input int w, input int d, input int exp_v);
    push(exp_v);
    set_lane0(w, d);
    for (int i = 0; i < beats; i++) do_beat();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    repeat (8) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // All lanes 1*2, single beat: 32 with 4 edges from the accepting edge
    for (int i = 0; i < LANES; i++) begin
      win[i*WI +: WI] = 8'd1;
      din[i*WI +: WI] = 8'd2;
    end
    set_cfg(1, 0, 1, 0, 0);
    push(32);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_with_result", busy, 1);
    drain();

    // 3-beat groups back to back; mid-group config changes ignored
    set_cfg(3, 0, 2, 5, 1);
    push(0);
    set_lane0(1, -10);
    do_beat();
    set_cfg(3, 1, 100, -50, 0);
    do_beat();
    do_beat();
    set_cfg(3, 1, 2, 5, 1);
    group(3, 1, -10, -25);
    drain();

    // Saturation, sign-extended bias, negative scale
    set_cfg(1, 0, 1, 0, 0);  group(1, 100, 3, 255);
    set_cfg(1, 1, 1, 0, 0);  group(1, 100, -3, -128);
    set_cfg(1, 0, 1, 0, 0);  group(1, 100, -3, 0);
    set_cfg(1, 1, 1, 0, 0);  group(1, 100, 1, 100);
    set_cfg(1, 1, 1, 0, 0);  group(1, 100, 2, 127);
    set_cfg(1, 1, 3, -5, 0); group(1, 1, 10, 15);
    set_cfg(1, 1, -2, 0, 0); group(1, 1, 10, -20);
    // Huge shifts collapse to 0 / -1
    set_cfg(1, 1, 1, 0, 63); group(1, 100, 3, 0);
    set_cfg(1, 1, 1, 0, 63); group(1, 100, -3, -1);
    set_cfg(1, 1, 1, 0, 48); group(1, 100, -3, -1);
    // Rounding vs truncation
`ifdef CONV_KERN_PAR_ROUND_EN
    set_cfg(1, 0, 1, 0, 1); group(1, 1, 3, 2);
    set_cfg(1, 1, 1, 0, 1); group(1, 1, -3, -1);
`else
    set_cfg(1, 0, 1, 0, 1); group(1, 1, 3, 1);
    set_cfg(1, 1, 1, 0, 1); group(1, 1, -3, -2);
`endif
    drain();

    // cfg_beats=0 means 256 beats: sum 256 >> 2 = 64
    set_cfg(0, 1, 1, 0, 2);
    group(256, 1, 1, 64);
    drain();

    // Backpressure: exactly FIFO_DEPTH results accepted, order preserved
    out_ready = 1'b0;
    set_cfg(1, 0, 1, 0, 0);
    acc_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (acc_n < 10) begin
        set_lane0(1, acc_n + 1);
        in_valid = 1'b1;
        if (in_ready) begin
          push(acc_n + 1);
          acc_n++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_n, FIFO_DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 1);
    hold_v = out_data;
    repeat (5) tick();
    chk("bp_hold_stable", out_data, 1);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    drain();

    // Reset mid-group: partial work discarded
    set_cfg(4, 0, 1, 0, 0);
    set_lane0(1, 50);
    do_beat();
    do_beat();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    group(4, 1, 1, 4);
    drain();

    // Reset with a finished result in flight: nothing emerges
    set_cfg(1, 0, 1, 0, 0);
    set_lane0(1, 7);
    do_beat();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("flight_rst_out_valid", out_valid, 0);
    set_cfg(2, 0, 1, 0, 0);
    group(2, 2, 3, 12);
    drain();
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
